coef_fetch: RTL and testbench

COEF_FETCH -- requirements
Module: coef_fetch

---
 rtl/coef_fetch.sv | 108 ++++++++++
 tb/tb_coef_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_fetch.sv
// Coefficient fetch: one ROM read per accepted decode result, C1 sign correction,
// and a 2-entry result FIFO with ready/valid handshakes on both sides.
module coef_fetch #(
  parameter int CW    = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_VALID,
  output logic            o_READY,
  input  logic [6:0]      i_ADDR_L_7B,
  input  logic [4:0]      i_ADDR_S_5B,
  input  logic            i_SEL_L_or_S,
  input  logic            i_COF_SIGN_REV_FLAG,
  output logic            o_ROM_L_EN,
  output logic [6:0]      o_ROM_L_ADDR,
  output logic            o_ROM_S_EN,
  output logic [4:0]      o_ROM_S_ADDR,
  input  logic [2*CW-1:0] i_ROM_L_DATA,
  input  logic [2*CW-1:0] i_ROM_S_DATA,
  output logic            o_VALID,
  input  logic            i_READY,
  output logic [CW-1:0]   o_C0,
  output logic [CW-1:0]   o_C1,
  output logic            o_SRC_L
);

  logic          inflight_q, inflight_d;
  logic          sel_q, flag_q;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] c0_mem_q [2];
  logic [CW-1:0] c1_mem_q [2];
  logic          src_mem_q [2];

  logic            accept, push, pop;
  logic [2:0]      occupancy;
  logic [2*CW-1:0] rom_word;
  logic [CW-1:0]   c1_raw, c1_fixed;

  // Outputs are forced quiet while reset is held, even though state clears at the edge.
  always_comb begin
    o_VALID    = ~i_RST & (count_q != 2'd0);
    pop        = o_VALID & i_READY;
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    o_READY    = ~i_RST & (occupancy < 3'(DEPTH));
    accept     = i_VALID & o_READY;
    inflight_d = accept;
    push       = inflight_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    o_ROM_L_EN   = accept & i_SEL_L_or_S;
    o_ROM_S_EN   = accept & ~i_SEL_L_or_S;
    o_ROM_L_ADDR = i_ADDR_L_7B;
    o_ROM_S_ADDR = i_ADDR_S_5B;
  end

  // ROM data arrives the cycle after the strobe, so stage 1 steers it here.
  always_comb begin
    rom_word = sel_q ? i_ROM_L_DATA : i_ROM_S_DATA;
    c1_raw   = rom_word[2*CW-1:CW];
    c1_fixed = flag_q ? (CW'(0) - c1_raw) : c1_raw;
  end

  always_comb begin
    o_C0    = i_RST ? '0   : c0_mem_q[rd_ptr_q];
    o_C1    = i_RST ? '0   : c1_mem_q[rd_ptr_q];
    o_SRC_L = i_RST ? 1'b0 : src_mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      inflight_q <= 1'b0;
      sel_q      <= 1'b0;
      flag_q     <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        c0_mem_q[i]  <= '0;
        c1_mem_q[i]  <= '0;
        src_mem_q[i] <= 1'b0;
      end
    end else begin
      inflight_q <= inflight_d;
      if (accept) begin
        sel_q  <= i_SEL_L_or_S;
        flag_q <= i_COF_SIGN_REV_FLAG;
      end
      count_q <= count_d;
      if (push) begin
        c0_mem_q[wr_ptr_q]  <= rom_word[CW-1:0];
        c1_mem_q[wr_ptr_q]  <= c1_fixed;
        src_mem_q[wr_ptr_q] <= sel_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  a_no_overflow : assert property (@(posedge i_CLK) disable iff (i_RST)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_coef_fetch.sv
// Bench for coef_fetch: directed vector table, hand-written corner sequences,
// and random traffic checked cycle by cycle against an outstanding-results queue model.
module tb_coef_fetch;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [6:0]    addr_l = '0;
  logic [4:0]    addr_s = '0;
  logic          sel = 1'b0;
  logic          flag = 1'b0;
  logic          rom_l_en, rom_s_en;
  logic [6:0]    rom_l_addr;
  logic [4:0]    rom_s_addr;
  logic [63:0]   rom_l_data = '0;
  logic [63:0]   rom_s_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [31:0]   o_c0, o_c1;
  logic          o_src_l;

  coef_fetch #(.CW(CW), .DEPTH(2)) dut (
    .i_CLK(clk), .i_RST(rst), .i_VALID(i_valid), .o_READY(o_ready),
    .i_ADDR_L_7B(addr_l), .i_ADDR_S_5B(addr_s), .i_SEL_L_or_S(sel),
    .i_COF_SIGN_REV_FLAG(flag),
    .o_ROM_L_EN(rom_l_en), .o_ROM_L_ADDR(rom_l_addr),
    .o_ROM_S_EN(rom_s_en), .o_ROM_S_ADDR(rom_s_addr),
    .i_ROM_L_DATA(rom_l_data), .i_ROM_S_DATA(rom_s_data),
    .o_VALID(o_valid), .i_READY(i_ready),
    .o_C0(o_c0), .o_C1(o_c1), .o_SRC_L(o_src_l)
  );

  always #5 clk = ~clk;

  logic [63:0] rom_l_mem [128];
  logic [63:0] rom_s_mem [32];

  // ROMs return garbage unless read the previous cycle.
  always @(posedge clk) begin
    if (rom_l_en) rom_l_data <= rom_l_mem[rom_l_addr];
    else          rom_l_data <= {$urandom, $urandom};
    if (rom_s_en) rom_s_data <= rom_s_mem[rom_s_addr];
    else          rom_s_data <= {$urandom, $urandom};
  end

  typedef struct {
    logic [31:0] c0;
    logic [31:0] c1;
    logic        src;
    int          avail;
  } res_t;

  res_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        s_valid, s_ready, s_len, s_sen, s_src;
  logic [31:0] s_c0, s_c1;
  int          s_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic sl, input logic [6:0] al,
                      input logic [4:0] as, input logic fl, input logic rdy);
    logic  e_valid, e_pop, e_ready, e_acc;
    logic [63:0] word;
    res_t  r;
    i_valid = v; sel = sl; addr_l = al; addr_s = as; flag = fl; i_ready = rdy;
    @(negedge clk);
    s_cyc = cyc; s_valid = o_valid; s_ready = o_ready; s_len = rom_l_en;
    s_sen = rom_s_en; s_c0 = o_c0; s_c1 = o_c1; s_src = o_src_l;
    e_valid = !rst && q.size() > 0 && q[0].avail <= cyc;
    e_pop   = e_valid && rdy;
    e_ready = !rst && (q.size() - (e_pop ? 1 : 0)) < 2;
    e_acc   = v && e_ready;
    check("o_READY", o_ready, e_ready);
    check("o_VALID", o_valid, e_valid);
    check("o_ROM_L_EN", rom_l_en, e_acc && sl);
    check("o_ROM_S_EN", rom_s_en, e_acc && !sl);
    if (e_acc && sl)  check("o_ROM_L_ADDR", rom_l_addr, al);
    if (e_acc && !sl) check("o_ROM_S_ADDR", rom_s_addr, as);
    if (e_valid) begin
      check("o_C0", o_c0, q[0].c0);
      check("o_C1", o_c1, q[0].c1);
      check("o_SRC_L", o_src_l, q[0].src);
    end
    if (rst) begin
      check("rst o_C0", o_c0, 0);
      check("rst o_C1", o_c1, 0);
      check("rst o_SRC_L", o_src_l, 0);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        word    = sl ? rom_l_mem[al] : rom_s_mem[as];
        r.c0    = word[31:0];
        r.c1    = fl ? (32'd0 - word[63:32]) : word[63:32];
        r.src   = sl;
        r.avail = cyc + 2;
        q.push_back(r);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'd0, 5'd0, 1'b0, rdy);
  endtask

  typedef struct {
    logic        sl;
    logic [6:0]  al;
    logic [4:0]  as;
    logic        fl;
    logic [63:0] word;
    logic [31:0] e_c0;
    logic [31:0] e_c1;
  } vec_t;

  vec_t tbl[6];
  int   n_acc, n_res, first_acc, last_res;
  logic [31:0] hold_c0, hold_c1;

  initial begin
    tbl[0] = '{1'b1, 7'h45, 5'h00, 1'b0, {32'h00001234, 32'h0000ABCD}, 32'h0000ABCD, 32'h00001234};
    tbl[1] = '{1'b0, 7'h00, 5'h13, 1'b1, {32'h00000001, 32'h00005555}, 32'h00005555, 32'hFFFFFFFF};
    tbl[2] = '{1'b0, 7'h00, 5'h13, 1'b1, {32'h80000000, 32'h00000007}, 32'h00000007, 32'h80000000};
    tbl[3] = '{1'b0, 7'h00, 5'h13, 1'b1, {32'h00000000, 32'h00000009}, 32'h00000009, 32'h00000000};
    tbl[4] = '{1'b1, 7'h7F, 5'h00, 1'b1, {32'hFFFFFFFF, 32'h00000000}, 32'h00000000, 32'h00000001};
    tbl[5] = '{1'b0, 7'h00, 5'h1F, 1'b0, {32'hDEADBEEF, 32'h0000CAFE}, 32'h0000CAFE, 32'hDEADBEEF};

    for (int i = 0; i < 128; i++) rom_l_mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 32; i++)  rom_s_mem[i] = {$urandom, $urandom};

    // Reset held with a request presented: nothing may be accepted.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7'h01, 5'h01, 1'b0, 1'b1);
    rst = 1'b0;
    idle(1, 1'b1);
    check("ready after reset", s_ready, 1'b1);

    // Vector table: single transactions, result expected two cycles after accept.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].sl) rom_l_mem[tbl[i].al] = tbl[i].word;
      else           rom_s_mem[tbl[i].as] = tbl[i].word;
      step(1'b1, tbl[i].sl, tbl[i].al, tbl[i].as, tbl[i].fl, 1'b1);
      check("vec L_EN", s_len, tbl[i].sl);
      check("vec S_EN", s_sen, !tbl[i].sl);
      idle(1, 1'b1);
      check("vec early valid", s_valid, 1'b0);
      idle(1, 1'b1);
      check("vec valid", s_valid, 1'b1);
      check("vec C0", s_c0, tbl[i].e_c0);
      check("vec C1", s_c1, tbl[i].e_c1);
      check("vec SRC", s_src, tbl[i].sl);
      idle(1, 1'b1);
    end

    // Backpressure: four requests with downstream stalled.
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i[0], 7'(i + 3), 5'(i + 3), i[1], 1'b0);
      if (s_len || s_sen) n_acc++;
    end
    check("bp accepted", n_acc, 2);
    check("bp ready low", s_ready, 1'b0);
    idle(1, 1'b0);
    hold_c0 = s_c0; hold_c1 = s_c1;
    idle(3, 1'b0);
    check("bp hold C0", s_c0, hold_c0);
    check("bp hold C1", s_c1, hold_c1);
    n_res = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      if (s_valid) n_res++;
    end
    check("bp delivered", n_res, 2);
    check("bp ready back", s_ready, 1'b1);

    // Streaming: 16 alternating requests, downstream always ready.
    n_acc = 0; n_res = 0; first_acc = -1; last_res = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, ~i[0], 7'(i * 5), 5'(i * 3), i[2], 1'b1);
      if (s_len || s_sen) begin
        n_acc++;
        if (first_acc < 0) first_acc = s_cyc;
      end
      if (s_valid) begin n_res++; last_res = s_cyc; end
    end
    for (int i = 0; i < 6; i++) begin
      idle(1, 1'b1);
      if (s_valid) begin n_res++; last_res = s_cyc; end
    end
    check("stream accepts", n_acc, 16);
    check("stream results", n_res, 16);
    check("stream span", last_res - first_acc, 17);

    // Reset one cycle after an accept: the transaction is discarded.
    step(1'b1, 1'b1, 7'h45, 5'h00, 1'b0, 1'b1);
    check("mid accept", s_len, 1'b1);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    idle(1, 1'b1);
    check("mid ready", s_ready, 1'b1);
    n_res = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_valid) n_res++;
      idle(1, 1'b1);
    end
    check("mid no valid", n_res, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 7'($urandom), 5'($urandom),
           $urandom_range(0, 1), ($urandom_range(0, 9) < 7));
    end
    rst = 1'b0;
    idle(6, 1'b1);
    check("drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
